// File: rtl/genome_loader_pkg.sv
// genome_loader_pkg -- shared types and constants for the genome loader.
//
// Contents:
//   state_t        : loader FSM states (IDLE, LD_CTRL, LD_G1, LD_G2, RUN, HOLD)
//   WR_SEL/WR_CTRL/WR_G1/WR_G2 : selection-engine write-mode encodings
//   state_wr_mode  : write mode driven to the engine while in a given state
//   cnt_width      : counter width needed to count 0 .. limit-1
package genome_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_CTRL = 3'd1,
    ST_LD_G1   = 3'd2,
    ST_LD_G2   = 3'd3,
    ST_RUN     = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  localparam logic [1:0] WR_SEL  = 2'b00;
  localparam logic [1:0] WR_CTRL = 2'b01;
  localparam logic [1:0] WR_G1   = 2'b10;
  localparam logic [1:0] WR_G2   = 2'b11;

  // Only the three load states write into the engine; every other state
  // leaves it in select/run mode.
  function automatic logic [1:0] state_wr_mode(input state_t st);
    case (st)
      ST_LD_CTRL: return WR_CTRL;
      ST_LD_G1:   return WR_G1;
      ST_LD_G2:   return WR_G2;
      default:    return WR_SEL;
    endcase
  endfunction

  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/genome_loader.sv
// genome_loader -- sequences one selection-engine operation per request:
// writes the control word, fetches two parent genomes from genome memory
// and streams them into the engine, waits for the engine to finish and
// holds the result until it is consumed.
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_ctrl, req_addr1, req_addr2 : control word and parent genome addresses
//   mem_rd_en/mem_rd_addr          : genome memory read request
//   mem_rd_data                    : read data, valid 1 cycle after mem_rd_en
//   pe_wr_mode, pe_data_in         : write port into the selection engine
//   pe_data_out, pe_done           : engine result and completion strobe
//   res_valid/res_ready            : result handshake
//   res_data, res_timeout          : result word and watchdog flag
//
// Optional build macro GLOADER_TIMEOUT_EN: adds a RUN watchdog that forces
// a zero result with res_timeout=1 after TIMEOUT_CYC cycles without
// pe_done. Without it RUN waits indefinitely and res_timeout is tied 0.
module genome_loader
  import genome_loader_pkg::*;
#(
  parameter int WORD_SZ     = 64,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WORD_SZ-1:0] req_ctrl,
  input  logic [ADDR_W-1:0]  req_addr1,
  input  logic [ADDR_W-1:0]  req_addr2,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [WORD_SZ-1:0] mem_rd_data,
  output logic [1:0]         pe_wr_mode,
  output logic [WORD_SZ-1:0] pe_data_in,
  input  logic [WORD_SZ-1:0] pe_data_out,
  input  logic               pe_done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WORD_SZ-1:0] res_data,
  output logic               res_timeout
);

  state_t state_reg;
  state_t state_next;

  logic [WORD_SZ-1:0] ctrl_reg;
  logic [ADDR_W-1:0]  addr1_reg;
  logic [ADDR_W-1:0]  addr2_reg;
  logic [WORD_SZ-1:0] res_data_reg;
  logic               accept;
  logic               timeout_hit;

  assign accept = (state_reg == ST_IDLE) && req_valid;

`ifdef GLOADER_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] run_cnt_reg;
  logic             res_timeout_reg;

  // run_cnt_reg is 0 on the first RUN cycle, so reaching CNT_LAST without
  // pe_done means TIMEOUT_CYC RUN cycles have elapsed.
  assign timeout_hit = (state_reg == ST_RUN) && (run_cnt_reg == CNT_LAST) && !pe_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_reg <= '0;
    end else if (state_reg != ST_RUN) begin
      run_cnt_reg <= '0;
    end else if (run_cnt_reg != CNT_LAST) begin
      run_cnt_reg <= run_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_timeout_reg <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      if (pe_done) begin
        res_timeout_reg <= 1'b0;
      end else if (timeout_hit) begin
        res_timeout_reg <= 1'b1;
      end
    end
  end

  assign res_timeout = res_timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign res_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. pe_done only matters in RUN; elsewhere it is ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (req_valid) state_next = ST_LD_CTRL;
      ST_LD_CTRL: state_next = ST_LD_G1;
      ST_LD_G1:   state_next = ST_LD_G2;
      ST_LD_G2:   state_next = ST_RUN;
      ST_RUN:     if (pe_done || timeout_hit) state_next = ST_HOLD;
      // Leaving HOLD goes to IDLE first, so a request can never be taken
      // in the same cycle the result is consumed.
      ST_HOLD:    if (res_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state. Memory reads are issued one state ahead of
  // the state that forwards the data, matching the 1-cycle read latency.
  always_comb begin
    req_ready   = 1'b0;
    res_valid   = 1'b0;
    pe_wr_mode  = state_wr_mode(state_reg);
    pe_data_in  = '0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (state_reg)
      ST_IDLE: req_ready = 1'b1;
      ST_LD_CTRL: begin
        pe_data_in  = ctrl_reg;
        mem_rd_en   = 1'b1;
        mem_rd_addr = addr1_reg;
      end
      ST_LD_G1: begin
        pe_data_in  = mem_rd_data;
        mem_rd_en   = 1'b1;
        mem_rd_addr = addr2_reg;
      end
      ST_LD_G2: pe_data_in = mem_rd_data;
      ST_HOLD:  res_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg  <= '0;
      addr1_reg <= '0;
      addr2_reg <= '0;
    end else if (accept) begin
      ctrl_reg  <= req_ctrl;
      addr1_reg <= req_addr1;
      addr2_reg <= req_addr2;
    end
  end

  // Result capture; untouched outside RUN so it stays stable through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      if (pe_done) begin
        res_data_reg <= pe_data_out;
      end else if (timeout_hit) begin
        res_data_reg <= '0;
      end
    end
  end

  assign res_data = res_data_reg;

endmodule
